// File: rtl/lifo_arbiter.sv
// Round-robin arbiter that serialises push/pop requests from NUM_REQ clients
// onto a single shared LIFO, tracking its occupancy and flagging desync.
module lifo_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 10,
  parameter int LIFO_SIZE = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           rsp_err,
  output logic [$clog2(LIFO_SIZE+1)-1:0] occupancy,
  output logic                           sync_err,
  output logic                           lifo_write,
  output logic                           lifo_read,
  output logic [DATA_W-1:0]              lifo_datain,
  input  logic [DATA_W-1:0]              lifo_dataout,
  input  logic                           lifo_val,
  input  logic                           lifo_full
);

  localparam int OCC_W = $clog2(LIFO_SIZE + 1);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, id, winner, cand;
  logic                found, op, err;
  logic [DATA_W-1:0]   data;
  logic                accept;

  // First valid requester at or after the RR pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % unsigned'(NUM_REQ));
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept = (state == IDLE) && found;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      id        <= '0;
      op        <= 1'b0;
      err       <= 1'b0;
      data      <= '0;
      occupancy <= '0;
      sync_err  <= 1'b0;
    end else begin
      if (accept) begin
        id     <= winner;
        op     <= req_op[winner];
        data   <= req_data[32'(winner)*DATA_W +: DATA_W];
        rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        err    <= req_op[winner] ? (occupancy == '0)
                                 : (occupancy == OCC_W'(LIFO_SIZE));
      end
      if (state == ISSUE && !err)
        occupancy <= op ? occupancy - OCC_W'(1) : occupancy + OCC_W'(1);
      // Desync: full flag vs count when idle, or a pop that returned no data.
      if ((state == IDLE && (lifo_full != (occupancy == OCC_W'(LIFO_SIZE)))) ||
          (state == RESP && !err && op && !lifo_val))
        sync_err <= 1'b1;
    end
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    lifo_write  = 1'b0;
    lifo_read   = 1'b0;
    lifo_datain = '0;
    case (state)
      IDLE: if (found && reset) req_ready[winner] = 1'b1;
      ISSUE: if (!err) begin
        lifo_write  = !op;
        lifo_read   = op;
        lifo_datain = data;
      end
      RESP: begin
        rsp_valid[id] = 1'b1;
        rsp_err       = err;
        if (!err && op) rsp_data = lifo_dataout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: directed scenarios plus random ops
// compared against a queue-based reference of the shared stack.
module tb_lifo_arbiter;

  localparam int NR = 2;
  localparam int DW = 10;
  localparam int LS = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_op = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic [DW-1:0]     rsp_data, lifo_datain, lifo_dataout;
  logic              rsp_err, sync_err, lifo_write, lifo_read, lifo_val, lifo_full;
  logic [2:0]        occupancy;

  int checks = 0;
  int errors = 0;

  lifo_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LIFO_SIZE(LS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .occupancy(occupancy), .sync_err(sync_err),
    .lifo_write(lifo_write), .lifo_read(lifo_read), .lifo_datain(lifo_datain),
    .lifo_dataout(lifo_dataout), .lifo_val(lifo_val), .lifo_full(lifo_full)
  );

  always #5 clock = ~clock;

  // Simple behavioural LIFO sharing the arbiter's reset.
  logic [DW-1:0] mem [0:LS-1];
  int            sp;
  logic          force_full = 1'b0;
  assign lifo_full = (sp == LS) || force_full;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp           <= 0;
      lifo_val     <= 1'b0;
      lifo_dataout <= '0;
    end else begin
      lifo_val <= 1'b0;
      if (lifo_write && sp < LS) begin
        mem[sp] <= lifo_datain;
        sp      <= sp + 1;
      end else if (lifo_read && sp > 0) begin
        lifo_dataout <= mem[sp-1];
        lifo_val     <= 1'b1;
        sp           <= sp - 1;
      end
    end
  end

  logic [DW-1:0] ref_q[$];
  int            ref_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {1'b0, req_ready, rsp_valid, rsp_data, rsp_err, occupancy, sync_err,
                lifo_write, lifo_read, lifo_datain}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    force_full = 1'b0;
    #1 check_all_zero("reset_outputs");
    @(negedge clock);
    reset = 1'b1;
    ref_q.delete();
    ref_rr = 0;
  endtask

  // One request from requester r, followed through accept, issue and response.
  task automatic run_op(input int r, input bit op, input logic [DW-1:0] d);
    bit            exp_err;
    logic [DW-1:0] exp_data;
    exp_err  = op ? (ref_q.size() == 0) : (ref_q.size() == LS);
    exp_data = '0;
    if (!exp_err) begin
      if (op) exp_data = ref_q.pop_back();
      else    ref_q.push_back(d);
    end
    @(negedge clock);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_data[r*DW +: DW] = d;
    #1 check("ready", 32'(req_ready), 32'(1 << r));
    @(posedge clock);
    #1 req_valid = '0;
    ref_rr = (r + 1) % NR;
    @(negedge clock);
    check("lifo_write", 32'(lifo_write), 32'(!exp_err && !op));
    check("lifo_read", 32'(lifo_read), 32'(!exp_err && op));
    if (!exp_err && !op) check("lifo_datain", 32'(lifo_datain), 32'(d));
    @(negedge clock);
    check("rsp_valid", 32'(rsp_valid), 32'(1 << r));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    @(negedge clock);
    check("occupancy", 32'(occupancy), 32'(ref_q.size()));
    check("rsp_idle", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    // Reset state
    #2 check_all_zero("reset_initial");
    do_reset();

    // Directed push/push/pop across requesters
    run_op(0, 1'b0, 10'h055);
    run_op(0, 1'b0, 10'h0AA);
    run_op(1, 1'b1, 10'h000);
    check("sync_after_t1", 32'(sync_err), 32'h0);

    // Contention: both push continuously, grants must alternate
    do_reset();
    req_op = '0;
    req_data = {10'($urandom), 10'($urandom)};
    @(negedge clock);
    req_valid = '1;
    for (int n = 0; n < 4; n++) begin
      int            w;
      logic [DW-1:0] wd;
      w  = ref_rr;
      wd = req_data[w*DW +: DW];
      #1 check("rr_grant", 32'(req_ready), 32'(1 << w));
      ref_q.push_back(wd);
      ref_rr = (w + 1) % NR;
      @(posedge clock);
      #1 req_data[w*DW +: DW] = 10'($urandom);
      @(negedge clock);
      check("rr_write", 32'({lifo_write, lifo_read}), 32'h2);
      check("rr_datain", 32'(lifo_datain), 32'(wd));
      check("rr_ready_issue", 32'(req_ready), 32'h0);
      @(negedge clock);
      check("rr_rsp", 32'(rsp_valid), 32'(1 << w));
      check("rr_ready_resp", 32'(req_ready), 32'h0);
      @(negedge clock);
    end
    req_valid = '0;
    check("rr_occupancy", 32'(occupancy), 32'(ref_q.size()));

    // Fill to the top, then overflow
    do_reset();
    for (int n = 0; n < LS + 1; n++) run_op(n % NR, 1'b0, 10'($urandom));
    check("full_occ", 32'(occupancy), 32'(LS));
    for (int n = 0; n < LS + 1; n++) run_op($urandom_range(0, NR-1), 1'b1, 10'($urandom));

    // Pop on empty straight after reset
    do_reset();
    run_op(1, 1'b1, 10'h3FF);

    // Reset asserted mid-op
    do_reset();
    @(negedge clock);
    req_valid[0] = 1'b1;
    req_op[0] = 1'b0;
    req_data[0 +: DW] = 10'h123;
    @(posedge clock);
    #1 req_valid = '0;
    #1 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    ref_q.delete();
    ref_rr = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("mid_reset_no_rsp", 32'(rsp_valid), 32'h0);
    end
    run_op(0, 1'b0, 10'h1C3);
    run_op(1, 1'b1, 10'h000);

    // Random ops against the reference stack
    do_reset();
    for (int n = 0; n < 40; n++)
      run_op($urandom_range(0, NR-1), 1'($urandom_range(0, 1)), 10'($urandom));
    check("rand_sync", 32'(sync_err), 32'h0);

    // Desync: full flag forced while occupancy is 2
    do_reset();
    run_op(0, 1'b0, 10'($urandom));
    run_op(1, 1'b0, 10'($urandom));
    check("sync_before", 32'(sync_err), 32'h0);
    @(negedge clock);
    force_full = 1'b1;
    @(negedge clock);
    check("sync_set", 32'(sync_err), 32'h1);
    force_full = 1'b0;
    repeat (3) @(negedge clock);
    check("sync_sticky", 32'(sync_err), 32'h1);
    do_reset();
    #1 check("sync_cleared", 32'(sync_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
